// File: rtl/fft_pkg.sv
// fft_pkg: shared definitions for the sequential DFT engine.
//   - fft_state_t  : FSM encoding, also driven onto the 'state' port
//   - acc_width    : MAC accumulator width for a given configuration
//   - twiddle_val  : constant function producing one twiddle ROM entry,
//                    round(2^(twid_w-1) * cos/sin(2*pi*idx/n_points)),
//                    clamped to +/-(2^(twid_w-1)-1)
// Twiddles are evaluated with integer Q30 Taylor series after reduction to
// the first quadrant, so elaboration needs no real-number math.
package fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_LOAD    = 2'b01,
        ST_COMPUTE = 2'b10,
        ST_OUTPUT  = 2'b11
    } fft_state_t;

    localparam int     FRAC_Q = 30;
    localparam longint PI_Q   = 64'sd3373259426;   // pi * 2^30

    function automatic int acc_width(input int sample_w, input int twid_w, input int n_points);
        return sample_w + twid_w + $clog2(n_points) + 1;
    endfunction

    // sin/cos of theta (Q30, 0 <= theta < pi/2), result in Q30
    function automatic longint taylor_q(input longint theta, input bit want_sin);
        longint x2;
        longint term;
        longint sum;
        int     base;
        x2   = (theta * theta) >>> FRAC_Q;
        term = want_sin ? theta : (longint'(1) <<< FRAC_Q);
        sum  = term;
        base = want_sin ? 1 : 0;
        for (int i = 1; i <= 12; i++) begin
            term = -((term * x2) >>> FRAC_Q) / longint'((2 * i + base - 1) * (2 * i + base));
            sum  = sum + term;
        end
        return sum;
    endfunction

    function automatic longint twiddle_val(input int idx, input int n_points,
                                           input int twid_w, input bit want_sin);
        int     quarter;
        int     quad;
        int     rem;
        longint theta;
        longint c_r;
        longint s_r;
        longint v;
        longint lim;
        quarter = n_points / 4;
        quad    = (idx / quarter) % 4;
        rem     = idx % quarter;
        theta   = (2 * PI_Q * longint'(rem)) / longint'(n_points);
        c_r     = taylor_q(theta, 1'b0);
        s_r     = taylor_q(theta, 1'b1);
        case (quad)
            0:       v = want_sin ?  s_r :  c_r;
            1:       v = want_sin ?  c_r : -s_r;
            2:       v = want_sin ? -s_r : -c_r;
            default: v = want_sin ? -c_r :  s_r;
        endcase
        v   = ((v <<< (twid_w - 1)) + (longint'(1) <<< (FRAC_Q - 1))) >>> FRAC_Q;
        lim = (longint'(1) <<< (twid_w - 1)) - 1;
        if (v > lim)
            v = lim;
        else if (v < -lim)
            v = -lim;
        return v;
    endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// fft_twiddle_rom: combinational twiddle lookup.
//   idx     in  clog2(N_POINTS) : twiddle index (k*n mod N)
//   cos_val out TWID_W signed   : round(2^(TWID_W-1)*cos(2*pi*idx/N))
//   sin_val out TWID_W signed   : round(2^(TWID_W-1)*sin(2*pi*idx/N))
module fft_twiddle_rom
    import fft_pkg::*;
#(
    parameter int N_POINTS = 16,
    parameter int TWID_W   = 16
) (
    input  logic        [$clog2(N_POINTS)-1:0] idx,
    output logic signed [TWID_W-1:0]           cos_val,
    output logic signed [TWID_W-1:0]           sin_val
);

    logic signed [TWID_W-1:0] cos_tab [N_POINTS];
    logic signed [TWID_W-1:0] sin_tab [N_POINTS];

    for (genvar i = 0; i < N_POINTS; i++) begin : g_tab
        localparam logic signed [TWID_W-1:0] COS_V = TWID_W'(twiddle_val(i, N_POINTS, TWID_W, 1'b0));
        localparam logic signed [TWID_W-1:0] SIN_V = TWID_W'(twiddle_val(i, N_POINTS, TWID_W, 1'b1));
        assign cos_tab[i] = COS_V;
        assign sin_tab[i] = SIN_V;
    end

    assign cos_val = cos_tab[idx];
    assign sin_val = sin_tab[idx];

endmodule

// File: rtl/fft_dft_engine.sv
// fft_dft_engine: sequential N-point real-input DFT, one complex MAC per cycle.
//   clk, rst   in            : clock, asynchronous active-high reset
//   start      in            : frame start, 'number' captured as x[0]
//   number     in  SAMPLE_W  : sample stream
//   state      out 2         : 00 IDLE, 01 LOAD, 10 COMPUTE, 11 OUTPUT
//   real_num   out OUT_W     : real part of bin bin_idx
//   img_num    out OUT_W     : imaginary part of bin bin_idx
//   bin_idx    out clog2(N)  : bin index k
//   out_valid  out 1         : one-cycle pulse per emitted bin
// Build option: FFT_SIGNED_IN_EN makes 'number' two's complement
// (sign-extended); otherwise samples are unsigned (zero-extended).
//
// state   | meaning
// IDLE    | waiting for start
// LOAD    | capturing x[1]..x[N-1], one per cycle
// COMPUTE | MAC over n = 0..N-1 for bin k
// OUTPUT  | bin k presented, advance k or finish
module fft_dft_engine
    import fft_pkg::*;
#(
    parameter int N_POINTS = 16,
    parameter int SAMPLE_W = 10,
    parameter int OUT_W    = 32,
    parameter int TWID_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [SAMPLE_W-1:0]         number,
    output logic [1:0]                  state,
    output logic [OUT_W-1:0]            real_num,
    output logic [OUT_W-1:0]            img_num,
    output logic [$clog2(N_POINTS)-1:0] bin_idx,
    output logic                        out_valid
);

    localparam int LOG_N  = $clog2(N_POINTS);
    localparam int ACC_W  = acc_width(SAMPLE_W, TWID_W, N_POINTS);
    localparam int PROD_W = SAMPLE_W + 1 + TWID_W;
    localparam int RND_W  = ACC_W - TWID_W + 1;
    localparam int SAT_W  = (RND_W > OUT_W) ? RND_W : OUT_W;

    localparam logic [LOG_N-1:0]        LAST_IDX = LOG_N'(N_POINTS - 1);
    localparam logic signed [ACC_W-1:0] RND_ADD  = {{(ACC_W-TWID_W+1){1'b0}}, 1'b1, {(TWID_W-2){1'b0}}};
    localparam logic signed [SAT_W-1:0] SAT_MAX  = {{(SAT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SAT_W-1:0] SAT_MIN  = ~SAT_MAX;

    fft_state_t               cur_state;
    logic [LOG_N-1:0]         k_cnt;
    logic [LOG_N-1:0]         n_cnt;
    logic [SAMPLE_W-1:0]      x_mem [N_POINTS];
    logic signed [ACC_W-1:0]  acc_re;
    logic signed [ACC_W-1:0]  acc_im;
    logic signed [ACC_W-1:0]  acc_re_next;
    logic signed [ACC_W-1:0]  acc_im_next;
    logic signed [SAMPLE_W:0] x_ext;
    logic signed [PROD_W-1:0] prod_re;
    logic signed [PROD_W-1:0] prod_im;
    logic [LOG_N-1:0]         twid_idx;
    logic signed [TWID_W-1:0] tw_cos;
    logic signed [TWID_W-1:0] tw_sin;

    // (k*n) mod N: the product evaluated at LOG_N bits wraps on its own
    assign twid_idx = LOG_N'(k_cnt * n_cnt);

    fft_twiddle_rom #(
        .N_POINTS (N_POINTS),
        .TWID_W   (TWID_W)
    ) u_rom (
        .idx     (twid_idx),
        .cos_val (tw_cos),
        .sin_val (tw_sin)
    );

    always_comb begin
`ifdef FFT_SIGNED_IN_EN
        x_ext = {x_mem[n_cnt][SAMPLE_W-1], x_mem[n_cnt]};
`else
        x_ext = {1'b0, x_mem[n_cnt]};
`endif
        prod_re     = PROD_W'(x_ext) * PROD_W'(tw_cos);
        prod_im     = PROD_W'(x_ext) * PROD_W'(tw_sin);
        acc_re_next = acc_re + ACC_W'(prod_re);
        acc_im_next = acc_im - ACC_W'(prod_im);
    end

    // round-half-up by 2^(TWID_W-1), then clamp into OUT_W
    function automatic logic [OUT_W-1:0] round_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] biased;
        logic signed [RND_W-1:0] rnd;
        logic signed [SAT_W-1:0] ext;
        biased = acc + RND_ADD;
        rnd    = RND_W'(biased >>> (TWID_W - 1));
        ext    = SAT_W'(rnd);
        if (ext > SAT_MAX)
            return SAT_MAX[OUT_W-1:0];
        else if (ext < SAT_MIN)
            return SAT_MIN[OUT_W-1:0];
        return ext[OUT_W-1:0];
    endfunction

    // The last MAC of a bin is folded straight into the output registers so
    // the bin is presented during the OUTPUT cycle itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= ST_IDLE;
            k_cnt     <= '0;
            n_cnt     <= '0;
            acc_re    <= '0;
            acc_im    <= '0;
            real_num  <= '0;
            img_num   <= '0;
            bin_idx   <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < N_POINTS; i++)
                x_mem[i] <= '0;
        end else begin
            out_valid <= 1'b0;
            case (cur_state)
                ST_IDLE: begin
                    if (start) begin
                        x_mem[0]  <= number;
                        n_cnt     <= LOG_N'(1);
                        cur_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    x_mem[n_cnt] <= number;
                    if (n_cnt == LAST_IDX) begin
                        n_cnt     <= '0;
                        k_cnt     <= '0;
                        acc_re    <= '0;
                        acc_im    <= '0;
                        cur_state <= ST_COMPUTE;
                    end else begin
                        n_cnt <= n_cnt + 1'b1;
                    end
                end
                ST_COMPUTE: begin
                    acc_re <= acc_re_next;
                    acc_im <= acc_im_next;
                    n_cnt  <= n_cnt + 1'b1;
                    if (n_cnt == LAST_IDX) begin
                        real_num  <= round_sat(acc_re_next);
                        img_num   <= round_sat(acc_im_next);
                        bin_idx   <= k_cnt;
                        out_valid <= 1'b1;
                        cur_state <= ST_OUTPUT;
                    end
                end
                ST_OUTPUT: begin
                    acc_re <= '0;
                    acc_im <= '0;
                    n_cnt  <= '0;
                    if (k_cnt == LAST_IDX) begin
                        cur_state <= ST_IDLE;
                    end else begin
                        k_cnt     <= k_cnt + 1'b1;
                        cur_state <= ST_COMPUTE;
                    end
                end
                default: cur_state <= ST_IDLE;
            endcase
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_fft_dft_engine.sv
// tb_fft_dft_engine: directed and random frames for fft_dft_engine (N=16),
// checked against a floating-point DFT reference with quantised twiddles.
module tb_fft_dft_engine;

    localparam int  N     = 16;
    localparam int  SW    = 10;
    localparam int  OW    = 32;
    localparam int  TW    = 16;
    localparam int  LOGN  = 4;
    localparam int  FRAME = N + N * (N + 1);
    localparam real PI    = 3.14159265358979323846;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [SW-1:0]   number;
    logic [1:0]      state;
    logic [OW-1:0]   real_num;
    logic [OW-1:0]   img_num;
    logic [LOGN-1:0] bin_idx;
    logic            out_valid;

    int     errors = 0;
    int     checks = 0;
    int     samp   [N];
    longint exp_re [N];
    longint exp_im [N];
    longint got_re [N];
    longint got_im [N];
    longint prev_re[N];
    longint prev_im[N];

    fft_dft_engine #(
        .N_POINTS (N),
        .SAMPLE_W (SW),
        .OUT_W    (OW),
        .TWID_W   (TW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .number    (number),
        .state     (state),
        .real_num  (real_num),
        .img_num   (img_num),
        .bin_idx   (bin_idx),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint labs(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic longint sval(input int s);
`ifdef FFT_SIGNED_IN_EN
        return (s >= (1 << (SW - 1))) ? longint'(s - (1 << SW)) : longint'(s);
`else
        return longint'(s);
`endif
    endfunction

    function automatic longint twid(input int idx, input bit is_sin);
        real    a;
        real    v;
        longint t;
        a = 2.0 * PI * real'(idx) / real'(N);
        v = (is_sin ? $sin(a) : $cos(a)) * 32768.0;
        t = (v >= 0.0) ? longint'($floor(v + 0.5)) : -longint'($floor(-v + 0.5));
        if (t > 32767)  t = 32767;
        if (t < -32767) t = -32767;
        return t;
    endfunction

    task automatic build_model();
        for (int k = 0; k < N; k++) begin
            longint are = 0;
            longint aim = 0;
            for (int n = 0; n < N; n++) begin
                are += sval(samp[n]) * twid((k * n) % N, 1'b0);
                aim -= sval(samp[n]) * twid((k * n) % N, 1'b1);
            end
            exp_re[k] = (are + 16384) >>> 15;
            exp_im[k] = (aim + 16384) >>> 15;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++)
            samp[i] = int'($urandom_range(0, (1 << SW) - 1));
    endtask

    // Drives one frame starting in the current (IDLE) cycle; returns in the
    // first IDLE cycle after the frame, or one cycle after an abort reset.
    task automatic run_frame(input string name, input int pulse_at, input int rst_at);
        int nv = 0;
        build_model();
        for (int c = 0; c <= FRAME; c++) begin
            if (c == 0)     check({name, " state_c0"}, state, 0);
            if (c == 1)     check({name, " state_load"}, state, 1);
            if (c == N)     check({name, " state_compute"}, state, 2);
            if (c == 2 * N) check({name, " state_output"}, state, 3);
            if (c == FRAME) begin
                check({name, " state_end_idle"}, state, 0);
                break;
            end
            if (out_valid === 1'b1) begin
                if (nv < N) begin
                    got_re[nv] = longint'($signed(real_num));
                    got_im[nv] = longint'($signed(img_num));
                    check($sformatf("%s bin_idx%0d", name, nv), bin_idx, nv);
                    check($sformatf("%s valid_cycle%0d", name, nv), c, 2 * N + nv * (N + 1));
                    check($sformatf("%s re%0d", name, nv), got_re[nv], exp_re[nv]);
                    check($sformatf("%s im%0d", name, nv), got_im[nv], exp_im[nv]);
                end
                nv++;
            end
            if (c == rst_at) begin
                rst   = 1'b1;
                start = 1'b0;
                #1;
                check({name, " rst_state"}, state, 0);
                check({name, " rst_re"}, real_num, 0);
                check({name, " rst_im"}, img_num, 0);
                check({name, " rst_bin"}, bin_idx, 0);
                check({name, " rst_valid"}, out_valid, 0);
                @(posedge clk);
                #1;
                rst = 1'b0;
                check({name, " rst_hold_state"}, state, 0);
                return;
            end
            start  = (c == 0) || (pulse_at >= 0 && c >= pulse_at && c < pulse_at + 3);
            number = (c < N) ? SW'(samp[c]) : SW'($urandom);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check({name, " bin_count"}, nv, N);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        number = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset state", state, 0);
        check("reset re", real_num, 0);
        check("reset im", img_num, 0);
        check("reset bin", bin_idx, 0);
        check("reset valid", out_valid, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle without start", state, 0);

        // impulse
        for (int i = 0; i < N; i++) samp[i] = 0;
        samp[0] = 100;
        run_frame("impulse", -1, -1);
        for (int k = 0; k < N; k++) begin
            check($sformatf("impulse const re%0d", k), got_re[k], 100);
            check($sformatf("impulse const im%0d", k), got_im[k], 0);
        end

        // DC, started in the first IDLE cycle after the previous frame
        for (int i = 0; i < N; i++) samp[i] = 10;
        run_frame("dc", -1, -1);
        check("dc bin0 re", got_re[0], 160);
        check("dc bin0 im", got_im[0], 0);
        for (int k = 1; k < N; k++)
            check($sformatf("dc leak%0d", k), (labs(got_re[k]) <= 2 && labs(got_im[k]) <= 2), 1);

        // project frame
        samp = '{10, 18, 19, 12, 3, 0, 6, 15, 20, 16, 7, 0, 2, 11, 19, 19};
        run_frame("project", -1, -1);
        check("project bin0 re", got_re[0], 177);
        check("project bin0 im", got_im[0], 0);
        check("project bin8 re", got_re[8], -5);
        check("project bin8 im", got_im[8], 0);
        for (int k = 1; k < N / 2; k++)
            check($sformatf("project conj%0d", k),
                  (labs(got_re[k] - got_re[N - k]) <= 2 && labs(got_im[k] + got_im[N - k]) <= 2), 1);
        for (int k = 0; k < N; k++) begin
            prev_re[k] = got_re[k];
            prev_im[k] = got_im[k];
        end

        // start held across the COMPUTE/OUTPUT boundary of bin 0
        run_frame("start_ignored", 2 * N - 1, -1);
        for (int k = 0; k < N; k++) begin
            check($sformatf("repeat re%0d", k), got_re[k], prev_re[k]);
            check($sformatf("repeat im%0d", k), got_im[k], prev_im[k]);
        end

        // abort mid-frame, then a fresh frame
        fill_random();
        run_frame("abort", -1, 40);
        fill_random();
        run_frame("after_abort", -1, -1);

        // all-ones first sample
        for (int i = 0; i < N; i++) samp[i] = 0;
        samp[0] = 1023;
        run_frame("ones", -1, -1);
`ifdef FFT_SIGNED_IN_EN
        check("ones bin0 re", got_re[0], -1);
        check("ones bin5 re", got_re[5], -1);
`else
        check("ones bin0 re", got_re[0], 1023);
        check("ones bin5 re", got_re[5], 1023);
`endif
        check("ones bin5 im", got_im[5], 0);

        // random frames
        for (int f = 0; f < 3; f++) begin
            fill_random();
            run_frame($sformatf("random%0d", f), -1, -1);
        end

        // outputs hold in IDLE
        repeat (5) @(posedge clk);
        #1;
        check("hold state", state, 0);
        check("hold re", longint'($signed(real_num)), got_re[N - 1]);
        check("hold bin", bin_idx, N - 1);
        check("hold valid", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
